// File: rtl/matmul_pkg.sv
// matmul_pkg: shared bridge FSM states and AXI response codes
package matmul_pkg;
   typedef enum logic [2:0] {IDLE, WR_ISSUE, WR_RESP, RD_ISSUE, RD_DATA, RD_RESP} state_t;
   localparam logic [1:0] RESP_OKAY = 2'b00;
endpackage

// File: rtl/axil_mem_if_bridge.sv
// axil_mem_if_bridge: AXI4-Lite slave to registered single-port memory, one transaction in flight
module axil_mem_if_bridge
   import matmul_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
   input  logic                  s_axil_awvalid,
   output logic                  s_axil_awready,
   input  logic [DATA_WIDTH-1:0] s_axil_wdata,
   input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
   input  logic                  s_axil_wvalid,
   output logic                  s_axil_wready,
   output logic [1:0]            s_axil_bresp,
   output logic                  s_axil_bvalid,
   input  logic                  s_axil_bready,
   input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
   input  logic                  s_axil_arvalid,
   output logic                  s_axil_arready,
   output logic [DATA_WIDTH-1:0] s_axil_rdata,
   output logic [1:0]            s_axil_rresp,
   output logic                  s_axil_rvalid,
   input  logic                  s_axil_rready,
   output logic                  mem_if_write,
   output logic [ADDR_WIDTH-1:0] mem_if_address,
   output logic [DATA_WIDTH-1:0] mem_if_write_data,
   output logic [STRB_WIDTH-1:0] mem_if_write_strb,
   input  logic [DATA_WIDTH-1:0] mem_if_read_data
);
   state_t                state_q, state_d;
   logic                  wr_last_q, wr_last_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
   logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
   logic                  grant_rd, grant_wr;
   // Round-robin grant in IDLE, next state and latched transaction fields
   always_comb begin
      grant_rd  = state_q == IDLE && s_axil_arvalid && (wr_last_q || !(s_axil_awvalid && s_axil_wvalid));
      grant_wr  = state_q == IDLE && s_axil_awvalid && s_axil_wvalid && !grant_rd;
      wr_last_d = grant_wr ? 1'b1 : grant_rd ? 1'b0 : wr_last_q;
      addr_d    = grant_rd ? s_axil_araddr : grant_wr ? s_axil_awaddr : addr_q;
      wdata_d   = grant_wr ? s_axil_wdata : wdata_q;
      wstrb_d   = grant_wr ? s_axil_wstrb : wstrb_q;
      rdata_d   = state_q == RD_DATA ? mem_if_read_data : rdata_q;
      state_d   = IDLE;
      case (state_q)
         IDLE:     state_d = grant_rd ? RD_ISSUE : grant_wr ? WR_ISSUE : IDLE;
         WR_ISSUE: state_d = WR_RESP;
         WR_RESP:  state_d = s_axil_bready ? IDLE : WR_RESP;
         RD_ISSUE: state_d = RD_DATA;
         RD_DATA:  state_d = RD_RESP;
         RD_RESP:  state_d = s_axil_rready ? IDLE : RD_RESP;
         default:  state_d = IDLE;
      endcase
   end
   // State and datapath registers; reset abandons any transaction in flight
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         wr_last_q <= 1'b1;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         wr_last_q <= wr_last_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         rdata_q   <= rdata_d;
      end
   end
   assign s_axil_awready    = grant_wr;
   assign s_axil_wready     = grant_wr;
   assign s_axil_arready    = grant_rd;
   assign s_axil_bvalid     = state_q == WR_RESP;
   assign s_axil_bresp      = RESP_OKAY;
   assign s_axil_rvalid     = state_q == RD_RESP;
   assign s_axil_rresp      = RESP_OKAY;
   assign s_axil_rdata      = rdata_q;
   assign mem_if_write      = state_q == WR_ISSUE;
   assign mem_if_address    = addr_q;
   assign mem_if_write_data = wdata_q;
   assign mem_if_write_strb = wstrb_q;
endmodule

// File: tb/tb_axil_mem_if_bridge.sv
// tb_axil_mem_if_bridge: scoreboard bench with attached registered strobe-merging memory
module tb_axil_mem_if_bridge;
   logic        clk = 0, reset = 1;
   logic [31:0] awaddr = 0, wdata = 0, araddr = 0, rdata, mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  wstrb = 0, mem_strb;
   logic        awvalid = 0, wvalid = 0, arvalid = 0, bready = 1, rready = 1;
   logic        awready, wready, bvalid, arready, rvalid, mem_write;
   logic [1:0]  bresp, rresp;
   logic [31:0] mem [0:255];
   logic [31:0] exp_mem [0:255];
   logic [31:0] rd_q [$];
   int          checks = 0, failures = 0, pulses = 0;

   axil_mem_if_bridge dut (
      .clk(clk), .reset(reset),
      .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
      .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
      .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
      .s_axil_araddr(araddr), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
      .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
      .mem_if_write(mem_write), .mem_if_address(mem_addr), .mem_if_write_data(mem_wdata),
      .mem_if_write_strb(mem_strb), .mem_if_read_data(mem_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
      return r;
   endfunction

   // Memory: registered read of the old word, strobe-merged write commit
   always @(posedge clk) begin
      if (mem_write) mem[mem_addr[9:2]] <= merge(mem[mem_addr[9:2]], mem_wdata, mem_strb);
      mem_rdata <= mem[mem_addr[9:2]];
      if (mem_write) pulses <= pulses + 1;
   end

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output int lat_w, output int lat_b, output logic [31:0] wa,
                           output logic [31:0] wd, output logic [3:0] ws, output logic [1:0] br);
      int n;
      lat_w = -1; lat_b = -1; wa = 0; wd = 0; ws = 0; br = 2'b11;
      @(negedge clk);
      awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
      n = 0;
      #1;
      while (!(awready && wready) && n < 50) begin @(negedge clk); #1; n++; end
      exp_mem[a[9:2]] = merge(exp_mem[a[9:2]], d, s);
      @(negedge clk);
      awvalid = 0; wvalid = 0;
      for (int i = 1; i < 20 && lat_b < 0; i++) begin
         if (mem_write && lat_w < 0) begin lat_w = i; wa = mem_addr; wd = mem_wdata; ws = mem_strb; end
         if (bvalid) begin lat_b = i; br = bresp; end
         if (lat_b < 0) @(negedge clk);
      end
   endtask

   task automatic do_read(input logic [31:0] a, output int lat, output logic [31:0] d, output logic [1:0] rr);
      int n;
      lat = -1; d = 0; rr = 2'b11;
      @(negedge clk);
      araddr = a; arvalid = 1;
      rd_q.push_back(exp_mem[a[9:2]]);
      n = 0;
      #1;
      while (!arready && n < 50) begin @(negedge clk); #1; n++; end
      @(negedge clk);
      arvalid = 0;
      for (int i = 1; i < 20 && lat < 0; i++) begin
         if (rvalid) begin lat = i; d = rdata; rr = rresp; end
         if (lat < 0) @(negedge clk);
      end
   endtask

   task automatic test_reset;
      reset = 1;
      repeat (3) @(negedge clk);
      checks++;
      if ({awready, wready, arready, bvalid, rvalid, mem_write} !== 6'b0) begin
         failures++; $display("FAIL reset_hs: got %b want 000000", {awready, wready, arready, bvalid, rvalid, mem_write});
      end
      checks++;
      if ({mem_addr, mem_wdata, mem_strb} !== 68'b0) begin
         failures++; $display("FAIL reset_mem: got addr=%h data=%h strb=%h want 0", mem_addr, mem_wdata, mem_strb);
      end
      checks++;
      if ({rdata, bresp, rresp} !== 36'b0) begin
         failures++; $display("FAIL reset_resp: got rdata=%h bresp=%b rresp=%b want 0", rdata, bresp, rresp);
      end
      reset = 0;
   endtask

   task automatic test_write;
      int lw, lb, p0;
      logic [31:0] wa, wd;
      logic [3:0] ws;
      logic [1:0] br;
      p0 = pulses;
      do_write(32'h10, 32'hDEADBEEF, 4'hF, lw, lb, wa, wd, ws, br);
      checks++;
      if (lw !== 1) begin failures++; $display("FAIL wr_pulse_lat: got %0d want 1", lw); end
      checks++;
      if (lb !== 2) begin failures++; $display("FAIL wr_bvalid_lat: got %0d want 2", lb); end
      checks++;
      if ({wa, wd, ws} !== {32'h10, 32'hDEADBEEF, 4'hF}) begin
         failures++; $display("FAIL wr_fields: got %h/%h/%h want 10/deadbeef/f", wa, wd, ws);
      end
      checks++;
      if (br !== 2'b00) begin failures++; $display("FAIL wr_bresp: got %b want 00", br); end
      @(negedge clk);
      checks++;
      if (bvalid !== 1'b0 || pulses - p0 !== 1) begin
         failures++; $display("FAIL wr_done: got bvalid=%b pulses=%0d want 0/1", bvalid, pulses - p0);
      end
   endtask

   task automatic test_read(input logic [31:0] a, input string nm);
      int lat;
      logic [31:0] d, e;
      logic [1:0] rr;
      do_read(a, lat, d, rr);
      e = rd_q.pop_front();
      checks++;
      if (lat !== 3) begin failures++; $display("FAIL %s_lat: got %0d want 3", nm, lat); end
      checks++;
      if (d !== e) begin failures++; $display("FAIL %s_data: got %h want %h", nm, d, e); end
      checks++;
      if (rr !== 2'b00) begin failures++; $display("FAIL %s_rresp: got %b want 00", nm, rr); end
      @(negedge clk);
      checks++;
      if (rvalid !== 1'b0) begin failures++; $display("FAIL %s_rdone: got rvalid=%b want 0", nm, rvalid); end
   endtask

   task automatic test_strobe_merge;
      int lw, lb;
      logic [31:0] wa, wd;
      logic [3:0] ws;
      logic [1:0] br;
      do_write(32'h10, 32'h00001234, 4'h3, lw, lb, wa, wd, ws, br);
      test_read(32'h10, "merge_lo");
      do_write(32'h24, 32'hA5A5A5A5, 4'hC, lw, lb, wa, wd, ws, br);
      test_read(32'h24, "merge_hi");
   endtask

   task automatic test_arbitration;
      int n;
      logic [31:0] d, e;
      @(negedge clk);
      reset = 1;
      @(negedge clk);
      reset = 0;
      araddr = 32'h10; awaddr = 32'h30; wdata = 32'h11223344; wstrb = 4'hF;
      arvalid = 1; awvalid = 1; wvalid = 1;
      rd_q.push_back(exp_mem[4]);
      #1;
      checks++;
      if ({arready, awready} !== 2'b10) begin failures++; $display("FAIL arb_first: got ar/aw=%b want 10", {arready, awready}); end
      @(negedge clk);
      arvalid = 0;
      d = 0; n = 0;
      #1;
      while (!(awready && wready) && n < 20) begin
         if (rvalid) d = rdata;
         @(negedge clk); #1; n++;
      end
      e = rd_q.pop_front();
      checks++;
      if (d !== e || n >= 20) begin failures++; $display("FAIL arb_read_then_write: got rdata=%h wait=%0d want %h", d, n, e); end
      exp_mem[12] = 32'h11223344;
      @(negedge clk);
      awvalid = 0; wvalid = 0;
      n = 0;
      while (!bvalid && n < 20) begin @(negedge clk); n++; end
      @(negedge clk);
      arvalid = 1; awvalid = 1; wvalid = 1; araddr = 32'h30;
      rd_q.push_back(exp_mem[12]);
      #1;
      checks++;
      if ({arready, awready} !== 2'b10) begin failures++; $display("FAIL arb_alternate: got ar/aw=%b want 10", {arready, awready}); end
      @(negedge clk);
      arvalid = 0; awvalid = 0; wvalid = 0;
      n = 0;
      while (!rvalid && n < 20) begin @(negedge clk); n++; end
      e = rd_q.pop_front();
      checks++;
      if (rdata !== e || n >= 20) begin failures++; $display("FAIL arb_alt_data: got %h want %h", rdata, e); end
      @(negedge clk);
   endtask

   task automatic test_bready_stall;
      int n, p0;
      bready = 0;
      @(negedge clk);
      awaddr = 32'h40; wdata = 32'hCAFEF00D; wstrb = 4'hF; awvalid = 1; wvalid = 1;
      exp_mem[16] = 32'hCAFEF00D;
      #1;
      n = 0;
      while (!awready && n < 20) begin @(negedge clk); #1; n++; end
      @(negedge clk);
      awaddr = 32'h44; wdata = 32'h00000055; wstrb = 4'h1;
      @(negedge clk);
      p0 = pulses;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++;
         if ({bvalid, awready, wready} !== 3'b100) begin
            failures++; $display("FAIL stall_hold%0d: got bvalid/aw/w=%b want 100", i, {bvalid, awready, wready});
         end
         @(negedge clk);
      end
      checks++;
      if (pulses !== p0) begin failures++; $display("FAIL stall_no_pulse: got %0d extra pulses want 0", pulses - p0); end
      bready = 1;
      @(negedge clk);
      #1;
      checks++;
      if (awready !== 1'b1) begin failures++; $display("FAIL stall_release: got awready=%b want 1", awready); end
      exp_mem[17] = merge(exp_mem[17], 32'h55, 4'h1);
      @(negedge clk);
      awvalid = 0; wvalid = 0;
      n = 0;
      while (!bvalid && n < 20) begin @(negedge clk); n++; end
      test_read(32'h40, "stall_rd0");
      test_read(32'h44, "stall_rd1");
   endtask

   task automatic test_reset_mid_read;
      bit seen;
      @(negedge clk);
      araddr = 32'h24; arvalid = 1;
      @(negedge clk);
      arvalid = 0;
      @(negedge clk);
      reset = 1;
      @(negedge clk);
      checks++;
      if ({awready, wready, arready, bvalid, rvalid, mem_write, rdata, mem_addr, mem_wdata, mem_strb, bresp, rresp} !== 110'b0) begin
         failures++; $display("FAIL rst_mid_read: got rv=%b rdata=%h addr=%h wd=%h strb=%h want 0", rvalid, rdata, mem_addr, mem_wdata, mem_strb);
      end
      reset = 0;
      seen = 0;
      repeat (10) begin @(negedge clk); if (rvalid) seen = 1; end
      checks++;
      if (seen !== 1'b0) begin failures++; $display("FAIL rst_no_rvalid: got rvalid seen=%b want 0", seen); end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin mem[i] = 0; exp_mem[i] = 0; end
      test_reset;
      test_write;
      test_read(32'h10, "read_back");
      test_strobe_merge;
      test_arbitration;
      test_bready_stall;
      test_reset_mid_read;
      checks++;
      if (rd_q.size() !== 0) begin failures++; $display("FAIL scoreboard_drain: got %0d left want 0", rd_q.size()); end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/axil_mem_if_bridge.md
AXIL_MEM_IF_BRIDGE -- requirements
Module: axil_mem_if_bridge

Interface
REQ-001 SHALL provide parameter ADDR_WIDTH, default 32, byte address width on both sides.
REQ-002 SHALL provide parameter DATA_WIDTH, default 32, data width (multiple of 8); STRB_WIDTH = DATA_WIDTH/8.
REQ-003 SHALL have port clk input 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset input 1, synchronous, active-high.
REQ-005 SHALL have AXI4-Lite write address ports: s_axil_awaddr in ADDR_WIDTH, s_axil_awvalid in 1, s_axil_awready out 1.
REQ-006 SHALL have AXI4-Lite write data ports: s_axil_wdata in DATA_WIDTH, s_axil_wstrb in STRB_WIDTH, s_axil_wvalid in 1, s_axil_wready out 1.
REQ-007 SHALL have AXI4-Lite write response ports: s_axil_bresp out 2, s_axil_bvalid out 1, s_axil_bready in 1.
REQ-008 SHALL have AXI4-Lite read address ports: s_axil_araddr in ADDR_WIDTH, s_axil_arvalid in 1, s_axil_arready out 1.
REQ-009 SHALL have AXI4-Lite read data ports: s_axil_rdata out DATA_WIDTH, s_axil_rresp out 2, s_axil_rvalid out 1, s_axil_rready in 1.
REQ-010 SHALL have memory ports: mem_if_write out 1, mem_if_address out ADDR_WIDTH, mem_if_write_data out DATA_WIDTH, mem_if_write_strb out STRB_WIDTH, mem_if_read_data in DATA_WIDTH (registered, valid one cycle after address).

Function
REQ-011 SHALL implement FSM states IDLE, WR_ISSUE, WR_RESP, RD_ISSUE, RD_DATA, RD_RESP; one transaction in flight.
REQ-012 In IDLE, write SHALL be accepted only when awvalid and wvalid are both high; awready and wready pulse together for that single cycle; next state WR_ISSUE.
REQ-013 In IDLE, read SHALL be accepted when arvalid high; arready pulses one cycle; next state RD_ISSUE.
REQ-014 When read and write are both ready in IDLE, grant SHALL go to the type not served last (round-robin bit, reset value = write served last, so read wins first).
REQ-015 WR_ISSUE SHALL drive mem_if_write=1 for exactly one cycle with latched address, data, strobe; next state WR_RESP.
REQ-016 WR_RESP SHALL hold bvalid=1, bresp=OKAY until bready; mem_if_write=0; returns to IDLE; awvalid→bvalid latency 2 cycles.
REQ-017 RD_ISSUE SHALL present latched read address for one cycle; RD_DATA SHALL capture mem_if_read_data into s_axil_rdata; RD_RESP SHALL hold rvalid=1, rresp=OKAY until rready; arvalid→rvalid latency 3 cycles.
REQ-018 mem_if_address SHALL hold its last value outside issue states; the write address presented in WR_ISSUE is also the read-back address the memory uses for strobe merging.
REQ-019 FSM SHALL guarantee ≥2 cycles between consecutive mem_if_write pulses and ≥1 cycle between a write pulse and the next read issue, so the memory's delayed commit never yields stale merge or read data.
REQ-020 Addresses SHALL pass through unmodified (byte addresses); no range checking; bresp/rresp always OKAY (2'b00).
REQ-021 Ready outputs SHALL be low in all states but IDLE; valids SHALL not drop before handshake.

Reset
REQ-022 On reset: state IDLE, all ready/valid outputs 0, mem_if_write 0, mem_if_address/write_data/write_strb 0, rdata 0, bresp/rresp 0, round-robin bit to "write last".
REQ-023 Reset mid-transaction SHALL abandon it; no pending response is emitted afterward.

Structure
REQ-024 The state enum and RESP_OKAY constant SHALL live in shared package matmul_pkg.
REQ-025 Block SHALL be a single module; no sub-module.

Verification
REQ-026 Write 0x10, data 0xDEADBEEF, strb 0xF, bready high → mem_if_write high 1 cycle after accept, bvalid 2 cycles after, bresp 0.
REQ-027 Read 0x10 after REQ-026 with memory model attached → rvalid 3 cycles after arvalid, rdata 0xDEADBEEF.
REQ-028 Write 0x10 strb 0x3 data 0x00001234 then read 0x10 → rdata 0xDEAD1234.
REQ-029 awvalid, wvalid, arvalid all raised in same cycle from reset → read granted first, then write; next simultaneous pair → read granted (alternation).
REQ-030 bready held low 5 cycles → bvalid stays high, awready stays low, no second mem_if_write.
REQ-031 reset asserted in RD_DATA → next cycle all outputs at reset values, rvalid never asserts.
